// File: rtl/rf_write_queue.sv
// In-order write-back queue feeding the register file write port, with a
// two-port read bypass that returns the newest pending value of a register.
module rf_write_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [AW-1:0]              in_addr,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       rf_stall,
   output logic                       rf_we,
   output logic [AW-1:0]              rf_waddr,
   output logic [WIDTH-1:0]           rf_wdata,
   input  logic [AW-1:0]              byp_raddr1,
   output logic                       byp_hit1,
   output logic [WIDTH-1:0]           byp_data1,
   input  logic [AW-1:0]              byp_raddr2,
   output logic                       byp_hit2,
   output logic [WIDTH-1:0]           byp_data2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    ent_addr [DEPTH];
   logic [WIDTH-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0] ent_valid;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push;
   logic             pop;
   logic             not_empty;
   logic [PW-1:0]    idx;

   assign not_empty = (count != '0);
   assign in_ready  = (count < CW'(DEPTH));
   // Writes to x0 are accepted to keep the producer moving but never stored.
   assign push      = in_valid & in_ready & (in_addr != '0);
   assign rf_we     = not_empty & ~rf_stall;
   assign pop       = rf_we;

   // Head is gated by occupancy so the unreset storage never leaks to the port.
   assign rf_waddr  = not_empty ? ent_addr[rd_ptr] : '0;
   assign rf_wdata  = not_empty ? ent_data[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage has no reset; the valid bits and count qualify every
   // read, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= in_addr;
         ent_data[wr_ptr] <= in_data;
      end
   end

   // Walk oldest to newest from the read pointer so the last match wins.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
      byp_hit2  = 1'b0;
      byp_data2 = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (ent_valid[idx] && (byp_raddr1 != '0) && (ent_addr[idx] == byp_raddr1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = ent_data[idx];
         end
         if (ent_valid[idx] && (byp_raddr2 != '0) && (ent_addr[idx] == byp_raddr2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = ent_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a queue-based reference model plus a
// scoreboard popped by a monitor whenever the DUT issues a register-file write.
module tb_rf_write_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int AW    = 5;

   typedef struct {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_addr;
   logic [WIDTH-1:0] in_data;
   logic             rf_stall;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [WIDTH-1:0] rf_wdata;
   logic [AW-1:0]    byp_raddr1;
   logic             byp_hit1;
   logic [WIDTH-1:0] byp_data1;
   logic [AW-1:0]    byp_raddr2;
   logic             byp_hit2;
   logic [WIDTH-1:0] byp_data2;
   logic [$clog2(DEPTH):0] count;

   int   checks   = 0;
   int   failures = 0;
   ent_t pend_q[$];   // reference contents of the queue
   ent_t exp_q[$];    // scoreboard of writes the register file must receive

   rf_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .byp_raddr1(byp_raddr1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
      .byp_raddr2(byp_raddr2), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic void model_byp(input logic [AW-1:0] ra, output logic hit,
                                     output logic [WIDTH-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (ra != '0)
         for (int i = 0; i < pend_q.size(); i++)
            if (pend_q[i].addr == ra) begin
               hit = 1'b1;
               d   = pend_q[i].data;
            end
   endfunction

   // Reference model: a plain FIFO of pending writes, x0 dropped, one drain per cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q.delete();
         exp_q.delete();
      end else if (in_valid && in_addr != '0 && pend_q.size() < DEPTH) begin
         if (pend_q.size() != 0 && !rf_stall) void'(pend_q.pop_front());
         pend_q.push_back('{in_addr, in_data});
         exp_q.push_back('{in_addr, in_data});
      end else if (pend_q.size() != 0 && !rf_stall) begin
         void'(pend_q.pop_front());
      end
   end

   // Monitor: compare status and bypass every cycle; pop the scoreboard on each write.
   always @(negedge clk) begin
      logic             mh1, mh2;
      logic [WIDTH-1:0] md1, md2;
      ent_t             e;
      if (reset_n) begin
         check("in_ready", 32'(in_ready), 32'(pend_q.size() < DEPTH));
         check("count", 32'(count), 32'(pend_q.size()));
         check("rf_we", 32'(rf_we), 32'(pend_q.size() != 0 && !rf_stall));
         if (pend_q.size() != 0) check("head_addr", 32'(rf_waddr), 32'(pend_q[0].addr));
         model_byp(byp_raddr1, mh1, md1);
         model_byp(byp_raddr2, mh2, md2);
         check("byp_hit1", 32'(byp_hit1), 32'(mh1));
         check("byp_data1", byp_data1, md1);
         check("byp_hit2", 32'(byp_hit2), 32'(mh2));
         check("byp_data2", byp_data2, md2);
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("drain_addr", 32'(rf_waddr), 32'(e.addr));
               check("drain_data", rf_wdata, e.data);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input logic st);
      @(posedge clk);
      #1;
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      rf_stall = st;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; rf_stall = 1'b0;
      byp_raddr1 = '0; byp_raddr2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_count", 32'(count), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_rf_we", 32'(rf_we), 32'(0));
      check("rst_waddr", 32'(rf_waddr), 32'(0));
      check("rst_wdata", rf_wdata, 32'(0));
      check("rst_byp", 32'({byp_hit1, byp_hit2}), 32'(0));
      @(posedge clk); #1; reset_n = 1'b1;

      // Single write, one-cycle latency.
      drive(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      check("t1_rf_we", 32'(rf_we), 32'(1));
      check("t1_waddr", 32'(rf_waddr), 32'(5));
      check("t1_wdata", rf_wdata, 32'hA5A5_A5A5);
      check("t1_count_before", 32'(count), 32'(1));
      @(posedge clk); #1;
      check("t1_count_after", 32'(count), 32'(0));

      // Stall and overfill: the fifth write is refused.
      for (int i = 1; i <= 5; i++) drive(1'b1, AW'(i), 32'h100 + 32'(i), 1'b1);
      drive(1'b0, '0, '0, 1'b1);
      @(negedge clk);
      check("t2_full_count", 32'(count), 32'(4));
      check("t2_full_ready", 32'(in_ready), 32'(0));
      drive(1'b0, '0, '0, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("t2_drained", 32'(count), 32'(0));

      // Same-address writes: bypass returns the newest, drain is oldest first.
      drive(1'b1, 5'd3, 32'd1, 1'b1);
      drive(1'b1, 5'd3, 32'd2, 1'b1);
      drive(1'b0, '0, '0, 1'b1);
      byp_raddr1 = 5'd3;
      @(negedge clk);
      check("t3_hit1", 32'(byp_hit1), 32'(1));
      check("t3_data1", byp_data1, 32'd2);
      drive(1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);

      // x0 writes dropped.
      byp_raddr2 = 5'd0;
      drive(1'b1, 5'd0, 32'hFFFF, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      check("t4_count", 32'(count), 32'(0));
      check("t4_rf_we", 32'(rf_we), 32'(0));
      check("t4_hit2", 32'(byp_hit2), 32'(0));

      // Steady stream across pointer wrap.
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b0);
         @(negedge clk);
         if (k > 0) begin
            check("t5_count", 32'(count), 32'(1));
            check("t5_ready", 32'(in_ready), 32'(1));
         end
      end
      drive(1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);

      // Randomized traffic with small address range to exercise bypass hits.
      for (int k = 0; k < 400; k++) begin
         byp_raddr1 = AW'($urandom_range(0, 7));
         byp_raddr2 = AW'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 99) < 40));
      end

      // Reset while draining with three entries queued.
      drive(1'b0, '0, '0, 1'b0);
      repeat (6) @(posedge clk);
      byp_raddr1 = 5'd9;
      drive(1'b1, 5'd9, 32'h9, 1'b1);
      drive(1'b1, 5'd10, 32'hA, 1'b1);
      drive(1'b1, 5'd11, 32'hB, 1'b1);
      drive(1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      check("t6_rf_we", 32'(rf_we), 32'(0));
      check("t6_count", 32'(count), 32'(0));
      check("t6_ready", 32'(in_ready), 32'(1));
      check("t6_hit1", 32'(byp_hit1), 32'(0));
      @(posedge clk); #1; reset_n = 1'b1;

      // Final drain, bounded.
      drive(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
